// File: rtl/player_input_sched.sv
// player_input_sched
// Turns decoded PS/2 key events into rate-limited single-cycle game
// commands and owns the top-level run state of the game.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (clears all state and outputs)
//   key_valid    one-cycle strobe qualifying key_code / key_break
//   key_code     scan code: 0x6B left, 0x74 right, 0x29 space, 0x5A enter
//   key_break    1 = release, 0 = make
//   missile_busy player missile in flight; inhibits fire
//   player_dead  level, player destroyed
//   move_left    one-cycle step-left command
//   move_right   one-cycle step-right command
//   fire         one-cycle missile spawn command
//   game_rst     one-cycle datapath reset pulse
//   state        00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//   held         {space, right, left} held-key flags
module player_input_sched #(
  parameter int MOVE_DIV      = 500000,
  parameter int FIRE_COOLDOWN = 2500000,
  parameter int CNT_W         = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_break,
  input  logic       missile_busy,
  input  logic       player_dead,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       game_rst,
  output logic [1:0] state,
  output logic [2:0] held
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ENTER = 8'h5A;

  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [CNT_W-1:0] FIRE_LOAD = CNT_W'(FIRE_COOLDOWN - 1);

  logic             enter_p1;
  logic [CNT_W-1:0] move_cnt;
  logic [CNT_W-1:0] cooldown;
  logic [1:0]       dir_prev;

  logic [1:0]       state_nxt;
  logic             restart;
  logic [2:0]       held_nxt;
  logic [1:0]       dir;
  logic             step;
  logic [CNT_W-1:0] move_cnt_nxt;
  logic [1:0]       dir_prev_nxt;
  logic             move_left_nxt;
  logic             move_right_nxt;
  logic             fire_nxt;
  logic [CNT_W-1:0] cooldown_nxt;

  // Run-state sequencing on the registered enter event. A death in PLAY
  // takes priority over a simultaneous enter.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enter_p1) begin
          state_nxt = ST_PLAY;
          restart   = 1'b1;
        end
      end
      ST_PLAY: begin
        if (player_dead)   state_nxt = ST_OVER;
        else if (enter_p1) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (enter_p1) state_nxt = ST_PLAY;
      end
      default: begin
        if (enter_p1) begin
          state_nxt = ST_PLAY;
          restart   = 1'b1;
        end
      end
    endcase
  end

  // Held-key tracking runs in every state; a restart wipes it so a new
  // game never starts with stale keys.
  always_comb begin
    held_nxt = held;
    if (key_valid) begin
      case (key_code)
        KEY_LEFT:  held_nxt[0] = ~key_break;
        KEY_RIGHT: held_nxt[1] = ~key_break;
        KEY_SPACE: held_nxt[2] = ~key_break;
        default:   held_nxt    = held;
      endcase
    end
    if (restart) held_nxt = 3'b000;
  end

  always_comb begin
    case (held[1:0])
      2'b01:   dir = DIR_LEFT;
      2'b10:   dir = DIR_RIGHT;
      default: dir = DIR_NONE;
    endcase
  end

  // A fresh direction steps immediately; a sustained one steps when the
  // counter reaches its last value.
  assign step = (dir != DIR_NONE) && ((dir != dir_prev) || (move_cnt == MOVE_LAST));

  always_comb begin
    move_cnt_nxt   = move_cnt;
    dir_prev_nxt   = dir_prev;
    move_left_nxt  = 1'b0;
    move_right_nxt = 1'b0;
    if (state == ST_PLAY) begin
      dir_prev_nxt   = dir;
      move_left_nxt  = step && (dir == DIR_LEFT);
      move_right_nxt = step && (dir == DIR_RIGHT);
      if (step || dir == DIR_NONE) move_cnt_nxt = '0;
      else                         move_cnt_nxt = move_cnt + 1'b1;
    end else if (state != ST_PAUSE || restart) begin
      // IDLE and OVER keep the movement state parked at zero; PAUSE freezes it.
      move_cnt_nxt = '0;
      dir_prev_nxt = DIR_NONE;
    end
  end

  // missile_busy is sampled in the decision cycle, so busy rising while
  // the pulse is already on the output cannot retract it.
  always_comb begin
    fire_nxt     = 1'b0;
    cooldown_nxt = cooldown;
    if (state == ST_PLAY) begin
      fire_nxt = held[2] && !missile_busy && (cooldown == '0);
      if (fire_nxt)              cooldown_nxt = FIRE_LOAD;
      else if (cooldown != '0)   cooldown_nxt = cooldown - 1'b1;
    end else if (state != ST_PAUSE || restart) begin
      cooldown_nxt = '0;
    end
  end

  // Stage p0 -> p1: register enter event, commands, and all state.
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_p1   <= 1'b0;
      state      <= ST_IDLE;
      held       <= 3'b000;
      move_cnt   <= '0;
      cooldown   <= '0;
      dir_prev   <= DIR_NONE;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      fire       <= 1'b0;
      game_rst   <= 1'b0;
    end else begin
      enter_p1   <= key_valid && (key_code == KEY_ENTER) && !key_break;
      state      <= state_nxt;
      held       <= held_nxt;
      move_cnt   <= move_cnt_nxt;
      cooldown   <= cooldown_nxt;
      dir_prev   <= dir_prev_nxt;
      move_left  <= move_left_nxt;
      move_right <= move_right_nxt;
      fire       <= fire_nxt;
      game_rst   <= restart;
    end
  end

endmodule
